playfield_tile_fetcher: RTL

- Video-side consumer of the playfield RAM's read port. It walks the 32x32 tile map in step with the raster counters and fetches each tile code over the synchronous RAM port B.
- It turns the tile code plus the scanline into a picture-ROM address, fetches the 2bpp row, and serialises 8 pixels per tile.
- Its output feeds the colour/priority mux that merges playfield and motion objects.

---
 rtl/playfield_tile_fetcher_pkg.sv | 33 +++
 rtl/playfield_tile_fetcher_if.sv | 17 +
 rtl/playfield_tile_fetcher_shifter.sv | 62 ++++++
 rtl/playfield_tile_fetcher.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/playfield_tile_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// pf_video_pkg : shared types and helpers for the playfield tile fetcher
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pf_video_pkg;

  localparam int TILE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RWAIT = 3'd2,
    GADDR = 3'd3,
    GWAIT = 3'd4
  } fsm_t;

  typedef struct packed {
    logic       flip_y;
    logic       flip_x;
    logic [5:0] tile;
  } tile_code_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/playfield_tile_fetcher_if.sv
// ---------------------------------------------------------------------------
// playfield_tile_fetcher_if : playfield RAM port B and picture ROM buses
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface playfield_tile_fetcher_if;
  logic [9:0]  pf_addr;
  logic [7:0]  pf_data;
  logic [9:0]  gfx_addr;
  logic [15:0] gfx_data;

  modport master (output pf_addr, output gfx_addr, input pf_data, input gfx_data);
  modport slave  (input pf_addr, input gfx_addr, output pf_data, output gfx_data);
endinterface

`default_nettype wire

// File: rtl/playfield_tile_fetcher_shifter.sv
// ---------------------------------------------------------------------------
// pf_pixel_shifter : 2bpp load/shift register with active-area gated output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pf_pixel_shifter
  import pf_video_pkg::*;
#(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 240
) (
  input  wire logic        clk,
  input  wire logic        rst_l,
  input  wire logic        pix_ce,
  input  wire logic [8:0]  hcount,
  input  wire logic [8:0]  vcount,
  input  wire logic [15:0] next_buf,
  output logic [1:0]       pixel,
  output logic             pixel_valid
);

  localparam logic [8:0] H_ACT_C = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT_C = 9'(V_ACTIVE);

  logic [15:0] shifter_q, shifter_d;
  logic [1:0]  pixel_q, pixel_d;
  logic        valid_q, valid_d;
  logic        active_w;

  always_comb begin
    shifter_d = shifter_q;
    pixel_d   = pixel_q;
    valid_d   = valid_q;
    active_w  = (hcount < H_ACT_C) && (vcount < V_ACT_C);
    if (pix_ce) begin
      pixel_d = active_w ? {shifter_q[15], shifter_q[7]} : 2'd0;
      valid_d = active_w;
      // The last pixel of a tile hands over to the prefetched row.
      if (hcount[2:0] == 3'd7) shifter_d = next_buf;
      else                     shifter_d = {shifter_q[14:8], 1'b0, shifter_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      shifter_q <= '0;
      pixel_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      shifter_q <= shifter_d;
      pixel_q   <= pixel_d;
      valid_q   <= valid_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/playfield_tile_fetcher.sv
// ---------------------------------------------------------------------------
// playfield_tile_fetcher : walks the tile map with the raster, fetches codes
// and picture rows, and serialises 2bpp playfield pixels.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module playfield_tile_fetcher
  import pf_video_pkg::*;
#(
  parameter int H_ACTIVE = 256,
  parameter int H_TOTAL  = 320,
  parameter int V_ACTIVE = 240,
  parameter int V_TOTAL  = 262
) (
  input  wire logic                clk,
  input  wire logic                rst_l,
  input  wire logic                pix_ce,
  input  wire logic [8:0]          hcount,
  input  wire logic [8:0]          vcount,
  input  wire logic                gfx_bank,
  playfield_tile_fetcher_if.master mem,
  output logic [1:0]               pixel,
  output logic                     pixel_valid,
  output logic                     overrun
);

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_TOT_C  = 10'(H_TOTAL);
  localparam logic [8:0] V_ACT_C  = 9'(V_ACTIVE);
  localparam logic [8:0] V_LAST_C = 9'(V_TOTAL - 1);

  fsm_t       state_q, state_d;
  logic [9:0] pf_addr_q, pf_addr_d;
  logic [2:0] tline_q, tline_d;
  logic [2:0] trow_q, trow_d;
  logic       bank_q, bank_d;
  tile_code_t code_q, code_d;
  logic [15:0] next_buf_q, next_buf_d;
  logic       overrun_q, overrun_d;

  logic       trigger_w;
  logic       fetch_w;
  logic [9:0] target_w;
  logic [8:0] tline_w;
  tile_code_t rd_code_w;

  always_comb begin
    trigger_w = pix_ce && (hcount[2:0] == 3'd0);
    target_w  = {1'b0, hcount} + 10'(TILE_W);
    tline_w   = vcount;
    if (target_w >= H_TOT_C) begin
      target_w = target_w - H_TOT_C;
      tline_w  = (vcount == V_LAST_C) ? 9'd0 : vcount + 9'd1;
    end
    // Lines past V_ACTIVE are never shown, so map rows beyond them are skipped.
    fetch_w = (target_w < H_ACT_C) && (tline_w < V_ACT_C);
  end

  always_comb begin
    state_d    = state_q;
    pf_addr_d  = pf_addr_q;
    tline_d    = tline_q;
    trow_d     = trow_q;
    bank_d     = bank_q;
    code_d     = code_q;
    next_buf_d = next_buf_q;
    overrun_d  = overrun_q;
    rd_code_w  = mem.pf_data;
    case (state_q)
      IDLE: begin
        if (trigger_w) begin
          if (fetch_w) begin
            state_d   = RADDR;
            pf_addr_d = {tline_w[7:3], target_w[7:3]};
            tline_d   = tline_w[2:0];
          end else begin
            next_buf_d = '0;
          end
        end
      end
      RADDR: state_d = RWAIT;
      RWAIT: begin
        code_d  = rd_code_w;
        trow_d  = tline_q;
        bank_d  = gfx_bank;
        state_d = GADDR;
      end
      GADDR: state_d = GWAIT;
      GWAIT: begin
        next_buf_d = code_q.flip_x ? {bitrev8(mem.gfx_data[15:8]), bitrev8(mem.gfx_data[7:0])}
                                   : mem.gfx_data;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (trigger_w && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      pf_addr_q  <= '0;
      tline_q    <= '0;
      trow_q     <= '0;
      bank_q     <= 1'b0;
      code_q     <= '0;
      next_buf_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pf_addr_q  <= pf_addr_d;
      tline_q    <= tline_d;
      trow_q     <= trow_d;
      bank_q     <= bank_d;
      code_q     <= code_d;
      next_buf_q <= next_buf_d;
      overrun_q  <= overrun_d;
    end
  end

  // Every field is a flop loaded on RWAIT, so the address only moves entering GADDR.
  assign mem.gfx_addr = {bank_q, code_q.tile, code_q.flip_y ? ~trow_q : trow_q};
  assign mem.pf_addr  = pf_addr_q;
  assign overrun      = overrun_q;

  pf_pixel_shifter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_shifter (
    .clk         (clk),
    .rst_l       (rst_l),
    .pix_ce      (pix_ce),
    .hcount      (hcount),
    .vcount      (vcount),
    .next_buf    (next_buf_q),
    .pixel       (pixel),
    .pixel_valid (pixel_valid)
  );

endmodule

`default_nettype wire
